// File: rtl/nios2cpu_led_sequencer.sv
// Avalon-MM LED sequencer: steps a 4-bit LED output through up to four pattern nibbles.
// Optional done interrupt (irq port, CONTROL[2]=IRQ_EN) is built when LED_SEQ_IRQ_EN is defined.
module nios2cpu_led_sequencer #(
  parameter int PRESCALE_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [3:0]  out_port
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic                  ctrl_run;
  logic                  ctrl_loop;
  logic [PRESCALE_W-1:0] period_reg;
  logic [PRESCALE_W-1:0] counter;
  logic [17:0]           pattern_reg;
  logic [3:0]            manual_reg;
  logic [3:0]            led_reg;
  logic [1:0]            step;
  logic [1:0]            step_inc;
  logic [1:0]            last;
  logic                  done;
  logic                  running;
  logic                  wr;
  logic                  unused_wdata;
`ifdef LED_SEQ_IRQ_EN
  logic                  ctrl_irq_en;
`endif

  assign wr           = chipselect & ~write_n;
  assign step_inc     = step + 2'd1;
  assign last         = pattern_reg[17:16];
  assign running      = (state == RUN);
  assign unused_wdata = ^writedata;

  // IDLE shows MANUAL directly so a MANUAL write appears on the very next cycle.
  assign out_port = (state == IDLE) ? manual_reg : led_reg;

`ifdef LED_SEQ_IRQ_EN
  assign irq = done & ctrl_irq_en;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ctrl_run    <= 1'b0;
      ctrl_loop   <= 1'b0;
      period_reg  <= '0;
      counter     <= '0;
      pattern_reg <= '0;
      manual_reg  <= '0;
      led_reg     <= '0;
      step        <= '0;
      done        <= 1'b0;
`ifdef LED_SEQ_IRQ_EN
      ctrl_irq_en <= 1'b0;
`endif
    end else begin
      if (wr && address == 3'd0) begin
        ctrl_run  <= writedata[0];
        ctrl_loop <= writedata[1];
`ifdef LED_SEQ_IRQ_EN
        ctrl_irq_en <= writedata[2];
`endif
      end
      if (wr && address == 3'd1) period_reg  <= writedata[PRESCALE_W-1:0];
      if (wr && address == 3'd2) pattern_reg <= writedata[17:0];
      if (wr && address == 3'd3) manual_reg  <= writedata[3:0];
      // Clear first so that a done set later in this block overrides it.
      if (wr && address == 3'd4) done <= 1'b0;

      if (wr && address == 3'd0 && writedata[0]) begin
        state   <= RUN;
        step    <= '0;
        counter <= period_reg;
        done    <= 1'b0;
        led_reg <= pattern_reg[3:0];
      end else if (wr && address == 3'd0) begin
        state   <= IDLE;
        step    <= '0;
        counter <= '0;
      end else begin
        case (state)
          RUN: begin
            if (counter != '0) begin
              counter <= counter - PRESCALE_W'(1);
            end else begin
              counter <= period_reg;
              if (step < last) begin
                step    <= step_inc;
                led_reg <= pattern_reg[{step_inc, 2'b00} +: 4];
              end else if (ctrl_loop) begin
                step    <= '0;
                led_reg <= pattern_reg[3:0];
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: begin
        readdata[1:0] = {ctrl_loop, ctrl_run};
`ifdef LED_SEQ_IRQ_EN
        readdata[2] = ctrl_irq_en;
`endif
      end
      3'd1:    readdata        = 32'(period_reg);
      3'd2:    readdata[17:0]  = pattern_reg;
      3'd3:    readdata[3:0]   = manual_reg;
      3'd4:    readdata        = {26'd0, step, 2'b00, done, running};
      default: readdata        = '0;
    endcase
  end

endmodule

// File: tb/tb_nios2cpu_led_sequencer.sv
// Self-checking bench for nios2cpu_led_sequencer: register vector table, directed corner
// sequences and randomized runs compared against a timing model of the LED sequence.
module tb_nios2cpu_led_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;
`ifdef LED_SEQ_IRQ_EN
  logic        irq;
  localparam logic [31:0] CTRL_MASK = 32'h7;
`else
  localparam logic [31:0] CTRL_MASK = 32'h3;
`endif

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  nios2cpu_led_sequencer #(.PRESCALE_W(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  rd_addr;
    logic [31:0] exp_rd;
    logic [3:0]  exp_out;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called just after a falling edge; the write is taken on the next rising edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("[TB] write addr=%0d data=0x%08h", a, d);
  endtask

  task automatic check_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  // Step k covers cycles k*(p+1) .. (k+1)*(p+1)-1 after the start write.
  function automatic logic [3:0] model_out(input int p, input logic [17:0] pat,
                                           input bit loop, input int t);
    int k;
    int lst;
    lst = int'(pat[17:16]);
    k   = t / (p + 1);
    if (loop) k = k % (lst + 1);
    else if (k > lst) k = lst;
    return pat[k*4 +: 4];
  endfunction

  function automatic logic [31:0] model_status(input int p, input logic [17:0] pat,
                                               input bit loop, input int t);
    int k;
    int lst;
    lst = int'(pat[17:16]);
    k   = t / (p + 1);
    if (loop) return 32'((k % (lst + 1)) * 16 + 1);
    if (k > lst) return 32'(lst * 16 + 2);
    return 32'(k * 16 + 1);
  endfunction

  task automatic run_model(input string name, input int p, input logic [17:0] pat,
                           input bit loop, input int cycles);
    bus_write(3'd1, 32'(p));
    bus_write(3'd2, {14'd0, pat});
    bus_write(3'd0, {30'd0, loop, 1'b1});
    for (int t = 0; t < cycles; t++) begin
      check($sformatf("%s out t=%0d", name, t), {28'd0, out_port},
            {28'd0, model_out(p, pat, loop, t)});
      check_rd($sformatf("%s status t=%0d", name, t), 3'd4, model_status(p, pat, loop, t));
      tick();
    end
  endtask

  initial begin
    logic [3:0]  exp_seq [8];
    logic [17:0] rpat;
    int          rp;
    bit          rloop;
    int          rcycles;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 3'd1, 32'h00FF_FFFF, 4'h0};
    vecs[1] = '{3'd2, 32'hFFFF_FFFF, 3'd2, 32'h0003_FFFF, 4'h0};
    vecs[2] = '{3'd0, 32'hFFFF_FFFE, 3'd0, 32'hFFFF_FFFE & CTRL_MASK, 4'h0};
    vecs[3] = '{3'd5, 32'hFFFF_FFFF, 3'd5, 32'h0, 4'h0};
    vecs[4] = '{3'd6, 32'hFFFF_FFFF, 3'd6, 32'h0, 4'h0};
    vecs[5] = '{3'd7, 32'hFFFF_FFFF, 3'd7, 32'h0, 4'h0};
    vecs[6] = '{3'd4, 32'hFFFF_FFFF, 3'd4, 32'h0, 4'h0};
    vecs[7] = '{3'd3, 32'h1234_5675, 3'd3, 32'h5, 4'h5};
    vecs[8] = '{3'd3, 32'h0000_0000, 3'd3, 32'h0, 4'h0};

    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset out_port", {28'd0, out_port}, 32'h0);
    for (int a = 0; a < 5; a++) check_rd($sformatf("reset rd%0d", a), 3'(a), 32'h0);

    for (int i = 0; i < 9; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata);
      check_rd($sformatf("vec%0d readback", i), vecs[i].rd_addr, vecs[i].exp_rd);
      check($sformatf("vec%0d out_port", i), {28'd0, out_port}, {28'd0, vecs[i].exp_out});
    end

    // MANUAL reaches the LEDs one cycle after the write
    bus_write(3'd3, 32'hA);
    check("manual out_port", {28'd0, out_port}, 32'hA);
    check_rd("manual readback", 3'd3, 32'h0000_000A);

    // One-shot run through four steps of three cycles each
    run_model("oneshot", 2, 18'h3_4321, 1'b0, 15);
    check_rd("oneshot final status", 3'd4, 32'h32);
    check("oneshot final out", {28'd0, out_port}, 32'h4);
    check_rd("oneshot ctrl keeps RUN", 3'd0, 32'h1);

    run_model("loop", 2, 18'h3_4321, 1'b1, 30);

    // Stop while at step 1
    run_model("stop", 2, 18'h3_4321, 1'b1, 4);
    bus_write(3'd0, 32'h0);
    check("stop out_port=manual", {28'd0, out_port}, 32'hA);
    check_rd("stop status", 3'd4, 32'h0);

    // Single-cycle sequence; STATUS write collides with done being set
    bus_write(3'd1, 32'h0);
    bus_write(3'd2, 32'h0000_0007);
    bus_write(3'd0, 32'h5);
    check("short run out", {28'd0, out_port}, 32'h7);
    check_rd("short run status", 3'd4, 32'h1);
    bus_write(3'd4, 32'h0);
    check_rd("done set wins", 3'd4, 32'h2);
    check("done out holds", {28'd0, out_port}, 32'h7);
`ifdef LED_SEQ_IRQ_EN
    check("irq high", {31'd0, irq}, 32'h1);
`endif
    tick();
    check_rd("done stays", 3'd4, 32'h2);
    bus_write(3'd4, 32'h0);
    check_rd("done cleared", 3'd4, 32'h0);
`ifdef LED_SEQ_IRQ_EN
    check("irq low", {31'd0, irq}, 32'h0);
`endif
    check_rd("ctrl irq_en bit", 3'd0, 32'h5 & CTRL_MASK);

    // PERIOD rewritten mid-step: current count finishes, later steps use new period
    exp_seq = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h8};
    bus_write(3'd1, 32'h3);
    bus_write(3'd2, 32'h0003_8421);
    bus_write(3'd0, 32'h1);
    for (int t = 0; t < 8; t++) begin
      check($sformatf("period change out t=%0d", t), {28'd0, out_port}, {28'd0, exp_seq[t]});
      if (t == 1) bus_write(3'd1, 32'h0);
      else tick();
    end
    check_rd("period change status", 3'd4, 32'h32);

    // Reset at step 2 with a simultaneous MANUAL write
    bus_write(3'd1, 32'h2);
    bus_write(3'd2, 32'h0003_4321);
    bus_write(3'd0, 32'h1);
    repeat (6) tick();
    check("pre-reset out", {28'd0, out_port}, 32'h3);
    reset = 1'b1; address = 3'd3; writedata = 32'hF; chipselect = 1'b1; write_n = 1'b0;
    tick();
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    check("post-reset out", {28'd0, out_port}, 32'h0);
    for (int a = 0; a < 5; a++) check_rd($sformatf("post-reset rd%0d", a), 3'(a), 32'h0);

    for (int it = 0; it < 20; it++) begin
      rp      = int'($urandom_range(0, 3));
      rpat    = 18'($urandom);
      rloop   = 1'($urandom_range(0, 1));
      rcycles = (int'(rpat[17:16]) + 1) * (rp + 1) * (rloop ? 2 : 1) + 2;
      run_model($sformatf("rand%0d", it), rp, rpat, rloop, rcycles);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
